// File: rtl/ocm_arbiter.sv
// Two-requester arbiter in front of a single OCM data port, with a WAIT-state watchdog.
// Define OCM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module ocm_arbiter #(
  parameter int unsigned WDT_CYCLES = 15
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         m0_request,
  input  logic         m0_rwn,
  input  logic [15:0]  m0_addr,
  input  logic [127:0] m0_wdata,
  output logic         m0_finish,
  output logic         m0_error,
  output logic [127:0] m0_rdata,
  input  logic         m1_request,
  input  logic         m1_rwn,
  input  logic [15:0]  m1_addr,
  input  logic [127:0] m1_wdata,
  output logic         m1_finish,
  output logic         m1_error,
  output logic [127:0] m1_rdata,
  output logic         ocm_request,
  output logic         ocm_rwn,
  output logic [15:0]  ocm_addr,
  output logic [127:0] ocm_write_data,
  input  logic         ocm_finish,
  input  logic [127:0] ocm_read_data
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 128;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q;
  logic          rwn_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          win;
  logic          capture;
  logic          done;
  logic          abort;

`ifdef OCM_ARB_RR_EN
  logic last_q;

  // Simultaneous requests go to whoever was not served last.
  always_comb begin
    win = ~m0_request;
    if (m0_request && m1_request) win = ~last_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)      last_q <= 1'b1;
    else if (capture) last_q <= win;
  end
`else
  // m0 wins whenever it is requesting.
  always_comb begin
    win = ~m0_request;
  end
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_request || m1_request) begin
          capture = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        // Normal completion takes precedence over a watchdog expiry in the same cycle.
        if (ocm_finish) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CW'(WDT_CYCLES)) begin
          done    = 1'b1;
          abort   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Access descriptor latched on the IDLE->ISSUE edge; later request changes are ignored.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      owner_q <= 1'b0;
      rwn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      owner_q <= win;
      rwn_q   <= win ? m1_rwn   : m0_rwn;
      addr_q  <= win ? m1_addr  : m0_addr;
      wdata_q <= win ? m1_wdata : m0_wdata;
    end
  end

  assign ocm_request    = (state_q == ISSUE);
  assign ocm_rwn        = rwn_q;
  assign ocm_addr       = addr_q;
  assign ocm_write_data = wdata_q;

  assign m0_finish = done  & ~owner_q;
  assign m1_finish = done  &  owner_q;
  assign m0_error  = abort & ~owner_q;
  assign m1_error  = abort &  owner_q;
  assign m0_rdata  = ocm_read_data;
  assign m1_rdata  = ocm_read_data;

endmodule
